f1_lights_seq: RTL and testbench

Parametrised start-light sequencer for the reaction-timer game. It lights `N_LEDS` lamps one at a time at a tick-based interval and holds them until the random delay expires. It then extinguishes them and measures the player's reaction time in ticks. It sits between the debounced key/tick generators and the LFSR, delay counter and 7-segment display path.

---
 rtl/f1_lights_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_f1_lights_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_lights_seq.sv
// f1_lights_seq: start-light sequencer for the reaction-timer game.
// Lights N_LEDS lamps one at a time every STEP_TICKS ticks and holds them
// until the random delay expires. It then puts them out and counts the
// player's reaction time in ticks.
// Optional feature: define F1_JUMP_START_EN to enable false-start
// detection (FAULT state and the jump_start flag).
module f1_lights_seq #(
    parameter int N_LEDS     = 10,
    parameter int STEP_TICKS = 500,
    parameter int RT_W       = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              trigger,
    input  logic              time_out,
    output logic              en_lfsr,
    output logic              start_delay,
    output logic [N_LEDS-1:0] ledr,
    output logic [RT_W-1:0]   react_time,
    output logic              result_valid,
    output logic              jump_start
);

    // A single-tick step still needs a 1-bit counter that always reads zero.
    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STEP_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_ZERO   = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);
    localparam logic [N_LEDS-1:0] LEDS_ALL    = {N_LEDS{1'b1}};
    localparam logic [N_LEDS-1:0] LEDS_OFF    = {N_LEDS{1'b0}};
    localparam logic [RT_W-1:0]   RT_MAX      = {RT_W{1'b1}};
    localparam logic [RT_W-1:0]   RT_ZERO     = {RT_W{1'b0}};
    localparam logic [RT_W-1:0]   RT_ONE      = RT_W'(1);

`ifdef F1_JUMP_START_EN
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LIGHT_UP = 3'd1,
        S_HOLD     = 3'd2,
        S_REACT    = 3'd3,
        S_FAULT    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LIGHT_UP = 3'd1,
        S_HOLD     = 3'd2,
        S_REACT    = 3'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [N_LEDS-1:0]   ledr_q, ledr_d;
    logic [RT_W-1:0]     rcnt_q, rcnt_d;
    logic [RT_W-1:0]     react_time_q, react_time_d;
    logic                result_valid_q, result_valid_d;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a false start takes priority over the delay expiring.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) state_d = S_LIGHT_UP;
                else         state_d = S_IDLE;
            end
            S_LIGHT_UP: begin
`ifdef F1_JUMP_START_EN
                if (trigger)                 state_d = S_FAULT;
                else if (ledr_q == LEDS_ALL) state_d = S_HOLD;
                else                         state_d = S_LIGHT_UP;
`else
                if (ledr_q == LEDS_ALL) state_d = S_HOLD;
                else                    state_d = S_LIGHT_UP;
`endif
            end
            S_HOLD: begin
`ifdef F1_JUMP_START_EN
                if (trigger)       state_d = S_FAULT;
                else if (time_out) state_d = S_REACT;
                else               state_d = S_HOLD;
`else
                if (time_out) state_d = S_REACT;
                else          state_d = S_HOLD;
`endif
            end
            S_REACT: begin
                if (trigger) state_d = S_IDLE;
                else         state_d = S_REACT;
            end
`ifdef F1_JUMP_START_EN
            S_FAULT: begin
                if (trigger) state_d = S_IDLE;
                else         state_d = S_FAULT;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        en_lfsr     = 1'b0;
        start_delay = 1'b0;
        case (state_q)
            S_LIGHT_UP: en_lfsr     = 1'b1;
            S_HOLD:     start_delay = 1'b1;
            default: begin
                en_lfsr     = 1'b0;
                start_delay = 1'b0;
            end
        endcase
    end

    // Datapath next values: step counter, lamps, reaction counter, result.
    always_comb begin
        step_d         = step_q;
        ledr_d         = ledr_q;
        rcnt_d         = rcnt_q;
        react_time_d   = react_time_q;
        result_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                ledr_d = LEDS_OFF;
                if (trigger) step_d = STEP_RELOAD;
                else         step_d = step_q;
            end
            S_LIGHT_UP: begin
                if (tick) begin
                    if (step_q == STEP_ZERO) begin
                        ledr_d = {ledr_q[N_LEDS-2:0], 1'b1};
                        step_d = STEP_RELOAD;
                    end else begin
                        step_d = step_q - STEP_ONE;
                    end
                end else begin
                    step_d = step_q;
                end
`ifdef F1_JUMP_START_EN
                if (trigger) ledr_d = LEDS_ALL;
                else         ledr_d = ledr_d;
`endif
            end
            S_HOLD: begin
                ledr_d = LEDS_ALL;
`ifdef F1_JUMP_START_EN
                if (trigger) begin
                    ledr_d = LEDS_ALL;
                end else if (time_out) begin
                    ledr_d = LEDS_OFF;
                    rcnt_d = RT_ZERO;
                end else begin
                    ledr_d = LEDS_ALL;
                end
`else
                if (time_out) begin
                    ledr_d = LEDS_OFF;
                    rcnt_d = RT_ZERO;
                end else begin
                    ledr_d = LEDS_ALL;
                end
`endif
            end
            S_REACT: begin
                ledr_d = LEDS_OFF;
                // A tick coinciding with the key press is not counted.
                if (trigger) begin
                    react_time_d   = rcnt_q;
                    result_valid_d = 1'b1;
                end else if (tick && (rcnt_q != RT_MAX)) begin
                    rcnt_d = rcnt_q + RT_ONE;
                end else begin
                    rcnt_d = rcnt_q;
                end
            end
`ifdef F1_JUMP_START_EN
            S_FAULT: begin
                if (trigger) ledr_d = LEDS_OFF;
                else         ledr_d = LEDS_ALL;
            end
`endif
            default: begin
                ledr_d = LEDS_OFF;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q         <= STEP_ZERO;
            ledr_q         <= LEDS_OFF;
            rcnt_q         <= RT_ZERO;
            react_time_q   <= RT_ZERO;
            result_valid_q <= 1'b0;
        end else begin
            step_q         <= step_d;
            ledr_q         <= ledr_d;
            rcnt_q         <= rcnt_d;
            react_time_q   <= react_time_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign ledr         = ledr_q;
    assign react_time   = react_time_q;
    assign result_valid = result_valid_q;

`ifdef F1_JUMP_START_EN
    logic jump_start_q, jump_start_d;

    // False-start flag is high exactly while the FAULT state is occupied.
    always_comb begin
        jump_start_d = (state_d == S_FAULT);
    end

    // False-start flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_start_q <= 1'b0;
        end else begin
            jump_start_q <= jump_start_d;
        end
    end

    assign jump_start = jump_start_q;
`else
    assign jump_start = 1'b0;
`endif

endmodule

// File: tb/tb_f1_lights_seq.sv
// Directed bench for f1_lights_seq: a vector table for the main sequence
// plus hand-written sequences for the corner cases. A second instance with
// a 4-bit result width exercises reaction-counter saturation.
module tb_f1_lights_seq;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        trigger;
    logic        time_out;
    logic        en_lfsr;
    logic        start_delay;
    logic [9:0]  ledr;
    logic [11:0] react_time;
    logic        result_valid;
    logic        jump_start;

    logic        trig2;
    logic        tout2;
    logic        en_lfsr2;
    logic        start_delay2;
    logic [1:0]  ledr2;
    logic [3:0]  react_time2;
    logic        result_valid2;
    logic        jump_start2;

    int n_vec;
    int n_err;

    f1_lights_seq #(.N_LEDS(10), .STEP_TICKS(3), .RT_W(12)) dut (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .time_out(time_out),
        .en_lfsr(en_lfsr), .start_delay(start_delay), .ledr(ledr),
        .react_time(react_time), .result_valid(result_valid), .jump_start(jump_start)
    );

    f1_lights_seq #(.N_LEDS(2), .STEP_TICKS(1), .RT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trig2), .time_out(tout2),
        .en_lfsr(en_lfsr2), .start_delay(start_delay2), .ledr(ledr2),
        .react_time(react_time2), .result_valid(result_valid2), .jump_start(jump_start2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        trig;
        logic        tout;
        int          nticks;
        int          nidle;
        logic [9:0]  ledr;
        logic        en;
        logic        sd;
        logic        rv;
        logic [11:0] rt;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic pulse_trig();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_main(input string nm, input logic [9:0] l, input logic en,
                            input logic sd, input logic js);
        chk({nm, ".ledr"}, 32'(ledr), 32'(l));
        chk({nm, ".en_lfsr"}, 32'(en_lfsr), 32'(en));
        chk({nm, ".start_delay"}, 32'(start_delay), 32'(sd));
        chk({nm, ".jump_start"}, 32'(jump_start), 32'(js));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic run_to_hold();
        pulse_trig();
        ticks(30);
        step();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        tick     = 1'b0;
        trigger  = 1'b0;
        time_out = 1'b0;
        trig2    = 1'b0;
        tout2    = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state of both instances.
        chk_main("reset", 10'h000, 1'b0, 1'b0, 1'b0);
        chk("reset.react_time", 32'(react_time), 32'd0);
        chk("reset.result_valid", 32'(result_valid), 32'd0);
        chk("reset2.ledr", 32'(ledr2), 32'd0);
        chk("reset2.react_time", 32'(react_time2), 32'd0);

        //          name         trig  tout  ticks idle ledr      en    sd    rv    rt
        vecs[0]  = '{"arm",      1'b1, 1'b0, 0,    0,   10'h000, 1'b1, 1'b0, 1'b0, 12'd0};
        vecs[1]  = '{"t2",       1'b0, 1'b0, 2,    0,   10'h000, 1'b1, 1'b0, 1'b0, 12'd0};
        vecs[2]  = '{"lamp1",    1'b0, 1'b0, 1,    0,   10'h001, 1'b1, 1'b0, 1'b0, 12'd0};
        vecs[3]  = '{"lamp2",    1'b0, 1'b0, 3,    0,   10'h003, 1'b1, 1'b0, 1'b0, 12'd0};
        vecs[4]  = '{"lamp4",    1'b0, 1'b0, 6,    0,   10'h00F, 1'b1, 1'b0, 1'b0, 12'd0};
        vecs[5]  = '{"lamp10",   1'b0, 1'b0, 18,   0,   10'h3FF, 1'b1, 1'b0, 1'b0, 12'd0};
        vecs[6]  = '{"hold",     1'b0, 1'b0, 0,    1,   10'h3FF, 1'b0, 1'b1, 1'b0, 12'd0};
        vecs[7]  = '{"hold_tk",  1'b0, 1'b0, 5,    2,   10'h3FF, 1'b0, 1'b1, 1'b0, 12'd0};
        vecs[8]  = '{"lights_out",1'b0,1'b1, 0,    0,   10'h000, 1'b0, 1'b0, 1'b0, 12'd0};
        vecs[9]  = '{"react250", 1'b0, 1'b0, 250,  0,   10'h000, 1'b0, 1'b0, 1'b0, 12'd0};
        vecs[10] = '{"result",   1'b1, 1'b0, 0,    0,   10'h000, 1'b0, 1'b0, 1'b1, 12'd250};
        vecs[11] = '{"rv_drop",  1'b0, 1'b0, 0,    1,   10'h000, 1'b0, 1'b0, 1'b0, 12'd250};
        vecs[12] = '{"idle_to",  1'b0, 1'b1, 0,    1,   10'h000, 1'b0, 1'b0, 1'b0, 12'd250};
        vecs[13] = '{"rearm",    1'b1, 1'b0, 0,    0,   10'h000, 1'b1, 1'b0, 1'b0, 12'd250};
        vecs[14] = '{"lu_to",    1'b0, 1'b1, 3,    0,   10'h001, 1'b1, 1'b0, 1'b0, 12'd250};

        foreach (vecs[k]) begin
            if (vecs[k].trig) pulse_trig();
            if (vecs[k].tout) begin
                time_out = 1'b1;
                step();
                time_out = 1'b0;
            end
            ticks(vecs[k].nticks);
            for (int j = 0; j < vecs[k].nidle; j++) step();
            chk_main(vecs[k].name, vecs[k].ledr, vecs[k].en, vecs[k].sd, 1'b0);
            chk({vecs[k].name, ".result_valid"}, 32'(result_valid), 32'(vecs[k].rv));
            chk({vecs[k].name, ".react_time"}, 32'(react_time), 32'(vecs[k].rt));
        end

        // Trigger and tick in the same REACT cycle: that tick is not counted.
        do_reset();
        run_to_hold();
        time_out = 1'b1;
        step();
        time_out = 1'b0;
        ticks(3);
        trigger = 1'b1;
        tick    = 1'b1;
        step();
        trigger = 1'b0;
        tick    = 1'b0;
        chk("trig_tick.react_time", 32'(react_time), 32'd3);
        chk("trig_tick.result_valid", 32'(result_valid), 32'd1);
        step();
        chk("trig_tick.rv_once", 32'(result_valid), 32'd0);

        // Trigger after two lamps.
        pulse_trig();
        ticks(6);
        chk_main("js_pre", 10'h003, 1'b1, 1'b0, 1'b0);
        pulse_trig();
`ifdef F1_JUMP_START_EN
        chk_main("js_fault", 10'h3FF, 1'b0, 1'b0, 1'b1);
        ticks(10);
        chk_main("js_stay", 10'h3FF, 1'b0, 1'b0, 1'b1);
        pulse_trig();
        chk_main("js_clear", 10'h000, 1'b0, 1'b0, 1'b0);
        chk("js_clear.react_time", 32'(react_time), 32'd3);
        chk("js_clear.result_valid", 32'(result_valid), 32'd0);
`else
        chk_main("js_ignored", 10'h003, 1'b1, 1'b0, 1'b0);
        ticks(24);
        chk_main("js_full", 10'h3FF, 1'b1, 1'b0, 1'b0);
        step();
        chk_main("js_hold", 10'h3FF, 1'b0, 1'b1, 1'b0);
        pulse_trig();
        chk_main("js_hold_trig", 10'h3FF, 1'b0, 1'b1, 1'b0);
`endif

        // Trigger and time_out in the same HOLD cycle.
        do_reset();
        run_to_hold();
        chk_main("both_pre", 10'h3FF, 1'b0, 1'b1, 1'b0);
        trigger  = 1'b1;
        time_out = 1'b1;
        step();
        trigger  = 1'b0;
        time_out = 1'b0;
`ifdef F1_JUMP_START_EN
        chk_main("both_fault", 10'h3FF, 1'b0, 1'b0, 1'b1);
        pulse_trig();
        chk_main("both_idle", 10'h000, 1'b0, 1'b0, 1'b0);
`else
        chk_main("both_react", 10'h000, 1'b0, 1'b0, 1'b0);
        ticks(7);
        pulse_trig();
        chk("both.react_time", 32'(react_time), 32'd7);
        chk("both.result_valid", 32'(result_valid), 32'd1);
`endif

        // Asynchronous reset in the middle of LIGHT_UP.
        pulse_trig();
        ticks(12);
        chk_main("mid_pre", 10'h00F, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_main("mid_rst", 10'h000, 1'b0, 1'b0, 1'b0);
        chk("mid_rst.react_time", 32'(react_time), 32'd0);
        chk("mid_rst.result_valid", 32'(result_valid), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk_main("mid_idle", 10'h000, 1'b0, 1'b0, 1'b0);
        pulse_trig();
        ticks(2);
        chk_main("restart0", 10'h000, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk_main("restart1", 10'h001, 1'b1, 1'b0, 1'b0);

        // Saturating reaction counter on the 4-bit instance.
        trig2 = 1'b1;
        step();
        trig2 = 1'b0;
        chk("sat.en_lfsr", 32'(en_lfsr2), 32'd1);
        ticks(1);
        chk("sat.ledr1", 32'(ledr2), 32'h1);
        ticks(1);
        chk("sat.ledr2", 32'(ledr2), 32'h3);
        step();
        chk("sat.hold", 32'(start_delay2), 32'd1);
        tout2 = 1'b1;
        step();
        tout2 = 1'b0;
        chk("sat.lights_out", 32'(ledr2), 32'h0);
        ticks(40);
        trig2 = 1'b1;
        step();
        trig2 = 1'b0;
        chk("sat.react_time", 32'(react_time2), 32'd15);
        chk("sat.result_valid", 32'(result_valid2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
